// File: rtl/uart_tx_fifo_if.sv
// ============================================================================
//  Module      : uart_tx_fifo_if
//  Description : Host-side word handshake between a producer and the UART
//                transmitter FIFO.
//                  data_in    - word to queue (bits above the frame length are
//                               ignored by the transmitter)
//                  send_valid - producer offers data_in this cycle
//                  send_ready - transmitter FIFO has room (not full)
//                  fifo_count - number of words currently queued
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

interface uart_tx_fifo_if #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4
);
    logic [DATA_W-1:0]             data_in;
    logic                          send_valid;
    logic                          send_ready;
    logic [$clog2(FIFO_DEPTH):0]   fifo_count;

    // Producer side
    modport master (
        output data_in,
        output send_valid,
        input  send_ready,
        input  fifo_count
    );

    // Transmitter side
    modport slave (
        input  data_in,
        input  send_valid,
        output send_ready,
        output fifo_count
    );
endinterface

`default_nettype wire

// File: rtl/uart_tx_fifo.sv
// ============================================================================
//  Module      : uart_tx_fifo
//  Description : UART transmitter with an input FIFO and run-time frame
//                format (data length, parity, stop bits, baud divisor).
//                Queued words go out back-to-back with no idle bit between
//                frames.
//  Ports       : clock        - system clock, rising edge
//                rst          - asynchronous active-low reset
//                baud_div     - bit period is baud_div+1 clocks
//                data_length  - data bits per frame, clamped to 5..DATA_W
//                parity_type  - 00/11 none, 01 odd, 10 even
//                stop_bits    - 0: one stop bit, 1: two stop bits
//                bus          - word handshake (data_in/send_valid/
//                               send_ready/fifo_count)
//                data_out     - serial line, idle high, registered
//                p_parity_out - parity bit of the current frame (0 if none)
//                tx_active    - a frame is in progress
//                tx_done      - one-cycle pulse as each frame finishes
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module uart_tx_fifo #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int DIV_W      = 16
) (
    input  wire logic             clock,
    input  wire logic             rst,
    input  wire logic [DIV_W-1:0] baud_div,
    input  wire logic [3:0]       data_length,
    input  wire logic [1:0]       parity_type,
    input  wire logic             stop_bits,
    uart_tx_fifo_if.slave         bus,
    output logic                  data_out,
    output logic                  p_parity_out,
    output logic                  tx_active,
    output logic                  tx_done
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    // ------------------------------------------------------------------
    // FIFO storage and pointers
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q,  count_d;

    // ------------------------------------------------------------------
    // Frame state
    // ------------------------------------------------------------------
    state_t            state_q;
    logic [DIV_W-1:0]  timer_q;
    logic [DIV_W-1:0]  div_q;
    logic [DATA_W-1:0] word_q;
    logic [IDX_W-1:0]  bit_idx_q;
    logic [IDX_W-1:0]  last_idx_q;
    logic              par_en_q;
    logic              stop2_q;
    logic              stop_idx_q;
    logic              data_out_q;
    logic              parity_q;
    logic              active_q;
    logic              done_q;

    logic              w_ready;
    logic              w_push;
    logic              w_pop;
    logic              w_frame_end;
    logic [3:0]        w_len;
    logic [DATA_W-1:0] w_head;
    logic [DATA_W-1:0] w_mask;
    logic              w_xor;
    logic              w_par_en;
    logic              w_par_bit;

    assign w_ready = (count_q != CNT_W'(FIFO_DEPTH));
    assign w_push  = bus.send_valid && w_ready;
    assign w_head  = mem_q[rd_ptr_q];

    // Last timer tick of the final stop bit
    assign w_frame_end = (state_q == S_STOP) && (timer_q == '0) &&
                         (stop_idx_q == stop2_q);

    // A word is taken either from idle or straight out of the final stop
    // bit, which is what keeps consecutive frames gap-free.
    assign w_pop = (count_q != '0) &&
                   ((state_q == S_IDLE) || w_frame_end);

    // ------------------------------------------------------------------
    // Frame configuration sampled at the moment a word is popped
    // ------------------------------------------------------------------
    always_comb begin
        if (data_length < 4'd5) begin
            w_len = 4'd5;
        end else if (data_length > 4'(DATA_W)) begin
            w_len = 4'(DATA_W);
        end else begin
            w_len = data_length;
        end
    end

    always_comb begin
        w_mask = '0;
        for (int i = 0; i < DATA_W; i++) begin
            w_mask[i] = (4'(i) < w_len);
        end
    end

    assign w_xor     = ^(w_head & w_mask);
    assign w_par_en  = (parity_type == 2'b01) || (parity_type == 2'b10);
    // Odd parity sets the bit when the data holds an even number of ones
    assign w_par_bit = (parity_type == 2'b01) ? ~w_xor :
                       (parity_type == 2'b10) ?  w_xor : 1'b0;

    // ------------------------------------------------------------------
    // FIFO bookkeeping
    // ------------------------------------------------------------------
    always_comb begin
        wr_ptr_d = wr_ptr_q + PTR_W'(w_push);
        rd_ptr_d = rd_ptr_q + PTR_W'(w_pop);
        count_d  = count_q + CNT_W'(w_push) - CNT_W'(w_pop);
    end

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; only the pointers define validity
    always_ff @(posedge clock) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= bus.data_in;
        end
    end

    // ------------------------------------------------------------------
    // Transmit FSM with registered outputs. The line register follows the
    // current state, so the line lags the state by one clock.
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            timer_q    <= '0;
            div_q      <= '0;
            word_q     <= '0;
            bit_idx_q  <= '0;
            last_idx_q <= '0;
            par_en_q   <= 1'b0;
            stop2_q    <= 1'b0;
            stop_idx_q <= 1'b0;
            data_out_q <= 1'b1;
            parity_q   <= 1'b0;
            active_q   <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;

            case (state_q)
                S_START:  data_out_q <= 1'b0;
                S_DATA:   data_out_q <= word_q[bit_idx_q];
                S_PARITY: data_out_q <= parity_q;
                default:  data_out_q <= 1'b1;
            endcase

            case (state_q)
                S_IDLE: begin
                end
                S_START: begin
                    if (timer_q == '0) begin
                        state_q   <= S_DATA;
                        bit_idx_q <= '0;
                        timer_q   <= div_q;
                    end else begin
                        timer_q <= timer_q - DIV_W'(1);
                    end
                end
                S_DATA: begin
                    if (timer_q == '0) begin
                        timer_q <= div_q;
                        if (bit_idx_q == last_idx_q) begin
                            state_q    <= par_en_q ? S_PARITY : S_STOP;
                            stop_idx_q <= 1'b0;
                        end else begin
                            bit_idx_q <= bit_idx_q + IDX_W'(1);
                        end
                    end else begin
                        timer_q <= timer_q - DIV_W'(1);
                    end
                end
                S_PARITY: begin
                    if (timer_q == '0) begin
                        state_q    <= S_STOP;
                        stop_idx_q <= 1'b0;
                        timer_q    <= div_q;
                    end else begin
                        timer_q <= timer_q - DIV_W'(1);
                    end
                end
                S_STOP: begin
                    if (timer_q == '0) begin
                        if (stop_idx_q != stop2_q) begin
                            stop_idx_q <= 1'b1;
                            timer_q    <= div_q;
                        end else begin
                            state_q  <= S_IDLE;
                            active_q <= 1'b0;
                            done_q   <= 1'b1;
                        end
                    end else begin
                        timer_q <= timer_q - DIV_W'(1);
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase

            // Starting a frame overrides the idle/stop transition above
            if (w_pop) begin
                state_q    <= S_START;
                active_q   <= 1'b1;
                word_q     <= w_head;
                div_q      <= baud_div;
                timer_q    <= baud_div;
                last_idx_q <= IDX_W'(w_len - 4'd1);
                par_en_q   <= w_par_en;
                parity_q   <= w_par_bit;
                stop2_q    <= stop_bits;
            end
        end
    end

    assign bus.send_ready = w_ready;
    assign bus.fifo_count = count_q;
    assign data_out       = data_out_q;
    assign p_parity_out   = parity_q;
    assign tx_active      = active_q;
    assign tx_done        = done_q;

endmodule

`default_nettype wire

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Parametrised UART transmitter: data width, FIFO depth and baud divisor width are parameters; frame format is selected at run time.
- Input words are accepted through a valid/ready handshake into an internal FIFO.
- Each word is serialised as start / data (LSB first) / optional parity / 1 or 2 stop bits.
- A programmable-divisor bit timer sets the bit period, and queued words are sent back-to-back with no idle gap.
- Sits between the host/bus interface and the TX pin; supersedes the fixed-format parity/framer/baud/PISO transmit chain.

Parameters:
DATA_W, 8, maximum data bits per frame (legal 5..9)
FIFO_DEPTH, 4, FIFO entries (power of 2, >=2)
DIV_W, 16, width of baud divisor

Ports:
clock  in  1  system clock, rising edge
rst  in  1  asynchronous active-low reset
baud_div  in  DIV_W  bit period = baud_div+1 clock cycles
data_length  in  4  data bits per frame; clamped to 5..DATA_W
parity_type  in  2  00/11 none, 01 odd, 10 even
stop_bits  in  1  0 = one stop bit, 1 = two
data_in  in  DATA_W  word to send; bits above data_length ignored
send_valid  in  1  data_in valid
send_ready  out  1  FIFO can accept (= !fifo_full)
fifo_count  out  $clog2(FIFO_DEPTH)+1  entries queued
data_out  out  1  serial line, idle high
p_parity_out  out  1  parity bit of current frame (0 if none)
tx_active  out  1  frame in progress
tx_done  out  1  one-cycle pulse at end of each frame

Behaviour:
- Reset (rst=0, async): data_out=1, tx_active=0, tx_done=0, p_parity_out=0, fifo_count=0, FIFO pointers cleared, FSM=IDLE, send_ready=1 once reset is released. A frame in progress is aborted with no tx_done.
- FIFO write: a word is written on the edge where send_valid && send_ready. send_ready is low when count==FIFO_DEPTH; pushes while full are not accepted. Push and pop on the same edge leave count unchanged.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE → START: on an edge with count!=0.
  - Pop the head word.
  - Latch baud_div, clamped data_length (L), parity_type, stop_bits.
  - Compute parity over the L LSBs: odd makes total ones (data+parity) odd, even makes it even; p_parity_out updates.
  - tx_active=1.
- Latency: word accepted at edge N (FIFO previously empty, FSM idle) → popped at edge N+1 → data_out=0 from edge N+2.
- Bit timer: loaded with the latched baud_div on entry to each bit, decrements each cycle; the bit ends on the cycle the timer is 0. Every bit, including each stop bit, lasts exactly baud_div+1 cycles. baud_div=0 gives one cycle per bit.
- START: data_out=0 → DATA.
- DATA: L bits, LSB first; a bit index counts 0..L-1 → PARITY if parity is enabled, else STOP.
- PARITY: data_out=p_parity_out → STOP.
- STOP: data_out=1 for 1 or 2 bit periods.
- End of the final stop bit:
  - tx_done=1 for exactly one cycle, on the edge the FSM leaves STOP.
  - If count!=0, pop and go directly to START with newly latched config; tx_active stays 1 and there is no idle bit.
  - Otherwise go to IDLE and tx_active=0 on the same edge.
- Frame length: 1+L+(parity?1:0)+(stop_bits?2:1) bits.
- Config inputs changing mid-frame have no effect until the next frame start.
- data_length<5 is treated as 5; data_length>DATA_W is treated as DATA_W.
- data_out is driven from a register (glitch-free).

Test Plan:
1. baud_div=3, L=8, no parity, 1 stop, push 0xA5 → data_out=0 from N+2, then 1,0,1,0,0,1,0,1, then 1; each bit 4 cycles; tx_done pulses once 40 cycles after start; tx_active low after.
2. L=7, even parity, data 0x55 → p_parity_out=0 and parity bit=0; repeat with odd parity → bit=1; frame = 10 bits.
3. FIFO_DEPTH=4, baud_div=0, send_valid held high for 6 consecutive cycles → w0..w4 accepted (w0 popped at N+1); send_ready low from N+4; 6th word accepted only after the next pop; all frames back-to-back with no idle cycle between stop and start; 5 tx_done pulses.
4. rst driven low mid data bit 3 with 2 words queued → data_out=1 immediately (asynchronously); fifo_count=0; no tx_done; after release the line stays idle.
5. data_length=3, stop_bits=1, baud_div=1, no parity → 5 data bits, 2 stop bits, frame = 16 cycles. data_length=12 with DATA_W=8 → 8 data bits.
6. baud_div changed from 3 to 7 during frame 1 of 2 queued → frame 1 keeps 4-cycle bits; frame 2 uses 8-cycle bits.
